btn_event_reader: RTL

Memory-mapped input peripheral that carries player button presses from the board into the processor, the inbound counterpart to the register-snooped LED output path. It synchronizes and debounces four raw push-buttons, turns each debounced press into an event, queues events in a small FIFO, and presents the oldest event on a 32-bit read word. The processor pops that word with a load from the mapped dmem address. It runs on the processor clock and sits beside RAM on the dmem read mux.

---
 rtl/btn_event_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/btn_event_reader.sv
// Button event reader: sync, debounce, press detect, arbitrate and queue
// button events; the oldest event is popped by a processor load.
module btn_event_reader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEPTH           = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn,
  input  logic        rd_en,
  output logic [31:0] q,
  output logic        pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    req_q, req_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          ovf_q, ovf_d;

  logic          empty;
  logic          full;
  logic          any_req;
  logic [1:0]    pick;
  logic [3:0]    pick_oh;
  logic          pop;
  logic          push;
  logic          drop;

  // Two-flop synchronizer and per-button debounce counters
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CMAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Lowest-index request wins; push into FIFO or drop on overflow
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    any_req = |req_q;
    pick    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_q[i]) pick = 2'(i);
    end
    pick_oh = any_req ? (4'b0001 << pick) : 4'b0000;
    pop     = rd_en & ~empty;
    push    = any_req & (~full | pop);
    drop    = any_req & full & ~pop;
    req_d   = (req_q | (stable_q & ~prev_q)) & ~pick_oh;
    wr_d    = wr_q + {{AW{1'b0}}, push};
    rd_d    = rd_q + {{AW{1'b0}}, pop};
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) mem_d[wr_q[AW-1:0]] = pick;
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (rd_en) begin
      ovf_d = 1'b0;
    end
  end

  // Read word presents the oldest event and the sticky overflow flag
  always_comb begin
    q       = '0;
    q[8]    = ovf_q;
    pending = ~empty;
    if (!empty) q[2:0] = {1'b0, mem_q[rd_q[AW-1:0]]} + 3'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      req_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
